// File: rtl/pr_pkg.sv
// Shared types and OCW2 command codes for the 8259A-style priority resolver.
// Optional build macro: PR_SPECIAL_FULLY_NESTED_EN (see priority_resolver).
package pr_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    typedef logic [IDX_W-1:0]   irq_idx_t;
    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [2:0]         ocw2_cmd_t;

    // OCW2[7:5] = {R, SL, EOI}
    localparam ocw2_cmd_t CMD_NS_EOI       = 3'b001;
    localparam ocw2_cmd_t CMD_S_EOI        = 3'b011;
    localparam ocw2_cmd_t CMD_ROT_NS_EOI   = 3'b101;
    localparam ocw2_cmd_t CMD_ROT_AEOI_SET = 3'b100;
    localparam ocw2_cmd_t CMD_ROT_AEOI_CLR = 3'b000;
    localparam ocw2_cmd_t CMD_ROT_S_EOI    = 3'b111;
    localparam ocw2_cmd_t CMD_SET_PRIO     = 3'b110;
    localparam ocw2_cmd_t CMD_NOP          = 3'b010;

    // Index one step below in priority, wrapping mod NUM_IRQ.
    function automatic irq_idx_t next_idx(input irq_idx_t i);
        return i + irq_idx_t'(1);
    endfunction

endpackage

// File: rtl/pr_rot_encoder.sv
// Rotating priority encoder: finds the set bit with the lowest priority
// level, where level(n) = n - base (mod NUM_IRQ).
module pr_rot_encoder
    import pr_pkg::*;
(
    input  irq_vec_t i_vec,
    input  irq_idx_t i_base,
    output logic     o_valid,
    output irq_idx_t o_index,
    output irq_idx_t o_level
);

    irq_idx_t w_level;

    // Scan from lowest priority up so the last hit is the winner.
    always_comb begin
        w_level = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_vec[i_base + irq_idx_t'(i)]) begin
                w_level = irq_idx_t'(i);
            end
        end
    end

    assign o_valid = |i_vec;
    assign o_level = w_level;
    assign o_index = i_base + w_level;

endmodule

// File: rtl/priority_resolver.sv
// 8259A-style priority resolver: IRR/ISR arbitration, INT handshake, rotation.
// Build macro PR_SPECIAL_FULLY_NESTED_EN lets an equal level re-interrupt.
module priority_resolver
    import pr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       freezing,
    input  logic [7:0] IRR_reg,
    input  logic [7:0] ISR_reg,
    input  logic [2:0] resetedISR_index,
    input  logic [7:0] OCW2,
    input  logic       INT_requestAck,
    output logic [2:0] serviced_interrupt_index,
    output logic [2:0] zeroLevelPriorityBit,
    output logic       INT_request
);

    irq_idx_t r_idx;
    irq_idx_t r_zlp;
    logic     r_req;
    logic     r_ack_q;

    logic     w_ack_edge;
    logic     w_cand_vld;
    irq_idx_t w_cand_idx;
    irq_idx_t w_cand_lvl;
    logic     w_blk_vld;
    irq_idx_t w_blk_idx;
    irq_idx_t w_blk_lvl;
    logic     w_prio_ok;
    logic     w_eligible;
    irq_idx_t w_zlp_nxt;

    assign w_ack_edge = INT_requestAck ^ r_ack_q;

    pr_rot_encoder u_irr_enc (
        .i_vec   (IRR_reg),
        .i_base  (r_zlp),
        .o_valid (w_cand_vld),
        .o_index (w_cand_idx),
        .o_level (w_cand_lvl)
    );

    pr_rot_encoder u_isr_enc (
        .i_vec   (ISR_reg),
        .i_base  (r_zlp),
        .o_valid (w_blk_vld),
        .o_index (w_blk_idx),
        .o_level (w_blk_lvl)
    );

`ifdef PR_SPECIAL_FULLY_NESTED_EN
    assign w_prio_ok = (w_cand_lvl <= w_blk_lvl);
`else
    assign w_prio_ok = (w_cand_lvl < w_blk_lvl);
`endif

    assign w_eligible = w_cand_vld && (!w_blk_vld || w_prio_ok);

    // Next rotation base from the OCW2 command; unknown codes hold.
    always_comb begin
        w_zlp_nxt = r_zlp;
        case (OCW2[7:5])
            CMD_NS_EOI,
            CMD_S_EOI:        w_zlp_nxt = '0;
            CMD_ROT_NS_EOI:   w_zlp_nxt = next_idx(resetedISR_index);
            CMD_ROT_S_EOI,
            CMD_SET_PRIO:     w_zlp_nxt = next_idx(OCW2[2:0]);
            CMD_ROT_AEOI_SET: begin
                if (w_ack_edge) begin
                    w_zlp_nxt = next_idx(r_idx);
                end
            end
            default:          w_zlp_nxt = r_zlp;
        endcase
    end

    // Rotation base and ack-edge tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zlp   <= '0;
            r_ack_q <= INT_requestAck;
        end else begin
            r_zlp   <= w_zlp_nxt;
            r_ack_q <= INT_requestAck;
        end
    end

    // Request handshake: clear on ack edge beats a new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= 1'b0;
            r_idx <= '0;
        end else if (r_req) begin
            if (w_ack_edge) begin
                r_req <= 1'b0;
            end
        end else if (!freezing && w_eligible) begin
            r_req <= 1'b1;
            r_idx <= w_cand_idx;
        end
    end

    assign serviced_interrupt_index = r_idx;
    assign zeroLevelPriorityBit     = r_zlp;
    assign INT_request              = r_req;

endmodule

// File: tb/tb_priority_resolver.sv
// Self-checking bench for priority_resolver: directed table, sweeps,
// and random stimulus against a level-based reference model.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       freezing;
    logic [7:0] IRR_reg;
    logic [7:0] ISR_reg;
    logic [2:0] resetedISR_index;
    logic [7:0] OCW2;
    logic       INT_requestAck;
    logic [2:0] serviced_interrupt_index;
    logic [2:0] zeroLevelPriorityBit;
    logic       INT_request;

    int n_cmp = 0;
    int n_bad = 0;

    int m_zlp, m_idx, m_req, m_ackq;

    typedef struct {
        bit       rst;
        bit       frz;
        bit [7:0] irr;
        bit [7:0] isr;
        bit [2:0] rix;
        bit [7:0] ocw;
        bit       ack;
        int       e_req;
        int       e_idx;
        int       e_zlp;
    } vec_t;

    vec_t tbl[26];

    priority_resolver dut (
        .clk                      (clk),
        .reset                    (reset),
        .freezing                 (freezing),
        .IRR_reg                  (IRR_reg),
        .ISR_reg                  (ISR_reg),
        .resetedISR_index         (resetedISR_index),
        .OCW2                     (OCW2),
        .INT_requestAck           (INT_requestAck),
        .serviced_interrupt_index (serviced_interrupt_index),
        .zeroLevelPriorityBit     (zeroLevelPriorityBit),
        .INT_request              (INT_request)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        bit r, bit f, bit [7:0] irr, bit [7:0] isr, bit [2:0] rix,
        bit [7:0] ocw, bit ack, int rq, int ix, int zl);
        vec_t v;
        v.rst = r;   v.frz = f;   v.irr = irr; v.isr = isr;
        v.rix = rix; v.ocw = ocw; v.ack = ack;
        v.e_req = rq; v.e_idx = ix; v.e_zlp = zl;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string nm, input int rq, input int ix,
                        input int zl);
        chk({nm, ".req"}, int'(INT_request), rq);
        chk({nm, ".idx"}, int'(serviced_interrupt_index), ix);
        chk({nm, ".zlp"}, int'(zeroLevelPriorityBit), zl);
    endtask

    // Reference: priority level of bit n is (n - base) mod 8; the
    // winner is the set bit with the smallest level.
    task automatic model_step();
        int nz, cl, bl, ci, lv;
        bit edge_a, elig;
        if (reset) begin
            m_zlp = 0; m_idx = 0; m_req = 0;
            m_ackq = int'(INT_requestAck);
            return;
        end
        edge_a = (int'(INT_requestAck) != m_ackq);
        nz = m_zlp;
        case (int'(OCW2[7:5]))
            1, 3: nz = 0;
            5:    nz = (int'(resetedISR_index) + 1) % 8;
            6, 7: nz = (int'(OCW2[2:0]) + 1) % 8;
            4:    if (edge_a) nz = (m_idx + 1) % 8;
            default: ;
        endcase
        cl = 8; bl = 8; ci = 0;
        for (int n = 0; n < 8; n++) begin
            lv = (n - m_zlp + 8) % 8;
            if (IRR_reg[n] && lv < cl) begin cl = lv; ci = n; end
            if (ISR_reg[n] && lv < bl) bl = lv;
        end
`ifdef PR_SPECIAL_FULLY_NESTED_EN
        elig = (cl < 8) && (bl == 8 || cl <= bl);
`else
        elig = (cl < 8) && (bl == 8 || cl < bl);
`endif
        if (m_req == 1 && edge_a) begin
            m_req = 0;
        end else if (m_req == 0 && !freezing && elig) begin
            m_req = 1;
            m_idx = ci;
        end
        m_zlp = nz;
        m_ackq = int'(INT_requestAck);
    endtask

    initial begin
        int sr, si, lo;
        bit [7:0] v;

`ifdef PR_SPECIAL_FULLY_NESTED_EN
        sr = 1; si = 3;
`else
        sr = 0; si = 2;
`endif
        tbl[0]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h40, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h20, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 8'hA4, 8'h00, 0, 8'h40, 0, 1, 2, 0);
        tbl[3]  = mk(0, 0, 8'hA4, 8'h00, 0, 8'h40, 1, 0, 2, 0);
        tbl[4]  = mk(0, 0, 8'hA4, 8'h00, 0, 8'h40, 1, 1, 2, 0);
        tbl[5]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h40, 0, 0, 2, 0);
        tbl[6]  = mk(0, 0, 8'h14, 8'h08, 0, 8'h40, 0, 1, 2, 0);
        tbl[7]  = mk(0, 0, 8'h14, 8'h08, 0, 8'h40, 1, 0, 2, 0);
        tbl[8]  = mk(0, 0, 8'h30, 8'h08, 0, 8'h40, 1, 0, 2, 0);
        tbl[9]  = mk(0, 0, 8'h08, 8'h08, 0, 8'h40, 1, sr, si, 0);
        tbl[10] = mk(0, 0, 8'h00, 8'h00, 0, 8'h40, 0, 0, si, 0);
        tbl[11] = mk(0, 1, 8'h80, 8'h00, 0, 8'h40, 0, 0, si, 0);
        tbl[12] = mk(0, 0, 8'h80, 8'h00, 0, 8'h40, 0, 1, 7, 0);
        tbl[13] = mk(0, 0, 8'h80, 8'h00, 0, 8'h40, 1, 0, 7, 0);
        tbl[14] = mk(0, 0, 8'h00, 8'h00, 0, 8'hC4, 1, 0, 7, 5);
        tbl[15] = mk(0, 0, 8'h11, 8'h00, 0, 8'h40, 1, 1, 0, 5);
        tbl[16] = mk(0, 0, 8'h00, 8'h00, 0, 8'h40, 0, 0, 0, 5);
        tbl[17] = mk(0, 0, 8'h00, 8'h00, 6, 8'hA0, 0, 0, 0, 7);
        tbl[18] = mk(0, 0, 8'h02, 8'h00, 0, 8'h40, 0, 1, 1, 7);
        tbl[19] = mk(1, 0, 8'h02, 8'h00, 0, 8'h40, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 8'h00, 8'h00, 0, 8'h80, 1, 0, 0, 1);
        tbl[21] = mk(0, 0, 8'h40, 8'h00, 0, 8'h80, 1, 1, 6, 1);
        tbl[22] = mk(0, 0, 8'h00, 8'h00, 0, 8'h80, 0, 0, 6, 7);
        tbl[23] = mk(0, 0, 8'h00, 8'h00, 0, 8'h60, 0, 0, 6, 0);
        tbl[24] = mk(0, 0, 8'h00, 8'h00, 0, 8'hE3, 0, 0, 6, 4);
        tbl[25] = mk(0, 0, 8'h00, 8'h00, 0, 8'hE7, 0, 0, 6, 0);

        reset = 1'b1; freezing = 1'b0;
        IRR_reg = '0; ISR_reg = '0; resetedISR_index = '0;
        OCW2 = 8'h40; INT_requestAck = 1'b0;
        step();
        chk3("reset", 0, 0, 0);
        reset = 1'b0;

        // Fixed-mode OCW2 sweep with nothing pending.
        for (int i = 0; i < 64; i++) begin
            v = 8'(i);
            OCW2 = {(v[5] ? 3'b011 : 3'b001), v[4:0]};
            step();
            chk3("ocw2_fixed", 0, 0, 0);
        end

        // Directed table.
        for (int k = 0; k < 26; k++) begin
            reset = tbl[k].rst;
            freezing = tbl[k].frz;
            IRR_reg = tbl[k].irr;
            ISR_reg = tbl[k].isr;
            resetedISR_index = tbl[k].rix;
            OCW2 = tbl[k].ocw;
            INT_requestAck = tbl[k].ack;
            step();
            chk3($sformatf("tbl%0d", k), tbl[k].e_req,
                 tbl[k].e_idx, tbl[k].e_zlp);
        end
        reset = 1'b0;

        // IRR sweep in fixed mode: each request pulses and is acked.
        OCW2 = 8'h20;
        for (int i = 1; i < 256; i++) begin
            v = 8'(i);
            lo = 0;
            for (int b = 7; b >= 0; b--) if (v[b]) lo = b;
            IRR_reg = v;
            step();
            chk3("sweep_set", 1, lo, 0);
            INT_requestAck = ~INT_requestAck;
            step();
            chk3("sweep_clr", 0, lo, 0);
        end

        // Random stimulus against the reference model.
        reset = 1'b1;
        model_step();
        step();
        chk3("rnd_reset", m_req, m_idx, m_zlp);
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            freezing = ($urandom_range(0, 9) < 2);
            IRR_reg = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1: ISR_reg = 8'h00;
                2:    ISR_reg = 8'h01 << $urandom_range(0, 7);
                default: ISR_reg = 8'($urandom);
            endcase
            resetedISR_index = 3'($urandom);
            OCW2 = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                OCW2[7:5] = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b000;
            if ($urandom_range(0, 9) < 3)
                INT_requestAck = ~INT_requestAck;
            model_step();
            step();
            chk3("rnd", m_req, m_idx, m_zlp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
